mem_access_unit: RTL and testbench

- Initiator side of the byte-addressed, little-endian, 32-bit data memory port.
- Accepts load/store requests from the core over a valid/ready handshake and sequences them onto the memory port.
- Loads: byte/halfword/word, with sign or zero extension.
- Stores: byte/halfword via read-modify-write (the memory port always writes 4 bytes); word directly.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer for the 32-bit little-endian data memory port
// Optional alignment checking is enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [1:0]               size_q, size_d;
  logic                     unsigned_q, unsigned_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              old_q, old_d;
  logic                     error_q, error_d;

  logic        misaligned;
  logic [31:0] addr_ext;
  logic        sign_fill;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_address[31:MEM_ADDR_BITS];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SIZE_HALF) && req_address[0]) ||
                      ((req_size == SIZE_WORD) && (req_address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    addr_ext = '0;
    addr_ext[MEM_ADDR_BITS-1:0] = addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_address[MEM_ADDR_BITS-1:0];
          wdata_d    = req_wdata;
          error_d    = 1'b0;
          if ((req_size == 2'b11) || misaligned) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        old_d   = mem_read_data;
        state_d = write_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  assign sign_fill = ~unsigned_q & ((size_q == SIZE_BYTE) ? old_q[7] : old_q[15]);

  // Outputs decode from state alone so reset clears them (mem_write in particular) at once.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_error     = 1'b0;
    mem_address    = '0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      READ: mem_address = addr_ext;
      WRITE: begin
        mem_address = addr_ext;
        mem_write   = 1'b1;
        case (size_q)
          SIZE_BYTE: mem_write_data = {old_q[31:8], wdata_q[7:0]};
          SIZE_HALF: mem_write_data = {old_q[31:16], wdata_q[15:0]};
          default:   mem_write_data = wdata_q;
        endcase
      end
      default: begin
        resp_valid = 1'b1;
        resp_error = error_q;
        if (!error_q && !write_q) begin
          case (size_q)
            SIZE_BYTE: resp_data = {{24{sign_fill}}, old_q[7:0]};
            SIZE_HALF: resp_data = {{16{sign_fill}}, old_q[15:0]};
            default:   resp_data = old_q;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-array memory model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          wr;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] mem [0:65535];
  logic [15:0] ma;

  mem_access_unit #(.MEM_ADDR_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ma = mem_address[15:0];
  always_comb mem_read_data = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma]         <= mem_write_data[7:0];
      mem[ma + 16'd1] <= mem_write_data[15:8];
      mem[ma + 16'd2] <= mem_write_data[23:16];
      mem[ma + 16'd3] <= mem_write_data[31:24];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: counts write cycles since the last response and checks each response.
  int wr_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      wr_cnt = 0;
    end else begin
      if (mem_write) wr_cnt++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          check("resp_latency_cycle", cyc, e.cyc);
          check("mem_write_cycles", wr_cnt, e.wr);
        end
        wr_cnt = 0;
      end
    end
  end

  // lat: edges after the accept edge before resp_valid appears.
  task automatic issue(input logic w, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int lat, input int exp_wr);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("req_ready_timeout", 32'd0, 32'd1);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = size;
    req_unsigned = uns;
    req_address  = addr;
    req_wdata    = wdata;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + 1 + lat;
    e.wr   = exp_wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_address = 32'hxxxx_xxxx;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_address = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'h11;
    mem[16'h11] = 8'h22;
    mem[16'h12] = 8'h83;
    mem[16'h13] = 8'h44;
    mem[16'h14] = 8'h55;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
    reset = 1'b0;

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h44832211, 1'b0, 1, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFF83, 1'b0, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h00000083, 1'b0, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00004483, 1'b0, 1, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00002211, 1'b0, 1, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h00000000, 1'b1, 0, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, 32'h00000000, 1'b1, 0, 0);
`else
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'hFFFF8322, 1'b0, 1, 0);
`endif
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b1, 0, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEAB, 32'h00000000, 1'b0, 2, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h4483AB11, 1'b0, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'h00000055, 1'b0, 1, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h00000000, 1'b0, 1, 1);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h24, 32'h0000BEEF, 32'h00000000, 1'b0, 2, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0000BEEF, 1'b0, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, 32'h4483AB11, 1'b0, 1, 0);
    drain();
    check("byte14_unchanged", {24'd0, mem[16'h14]}, 32'h55);

    // Abort a sub-word store while it is in WRITE.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_address = 32'h13;
    req_wdata = 32'h00000099;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reached_write_state", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("mem_write_async_drop", {31'd0, mem_write}, 32'd0);
    check("req_ready_in_reset", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    check("byte13_kept", {24'd0, mem[16'h13]}, 32'h44);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h4483AB11, 1'b0, 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
